// File: rtl/mult_stim_gen.sv
// Stimulus generator for the signed parity-checked multiplier: LFSR-driven operand
// pairs, request/result handshake with timeout recovery, and per-run statistics.
module mult_stim_gen #(
    parameter int          DATA_W  = 16,
    parameter int          ERR_W   = 2,
    parameter logic [31:0] SEED    = 32'hACE1_1234,
    parameter int          TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               mode,
    input  logic [15:0]              count,
    input  logic                     result_valid,
    output logic signed [DATA_W-1:0] arg_a,
    output logic                     arg_a_parity,
    output logic signed [DATA_W-1:0] arg_b,
    output logic                     arg_b_parity,
    output logic                     req,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              tx_cnt,
    output logic [15:0]              err_cnt,
    output logic [15:0]              tmo_cnt
);

    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int          WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic signed [DATA_W-1:0] OP_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN_A,
        S_GEN_B,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [31:0]         lfsr;
    logic [15:0]         count_lat;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [2:0]               sel;
    logic [ERR_W-1:0]         errf;
    logic signed [DATA_W-1:0] gen_data;
    logic signed [DATA_W-1:0] gen_op;
    logic                     gen_inj;
    logic                     gen_par;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
    endfunction

    function automatic logic signed [DATA_W-1:0] pick_operand(
        input logic [1:0]               m,
        input logic [2:0]               s,
        input logic signed [DATA_W-1:0] data
    );
        logic signed [DATA_W-1:0] op;
        if (m == 2'd1) begin
            op = data;
        end else if (m == 2'd2) begin
            case (s[1:0])
                2'b00:   op = OP_MIN;
                2'b01:   op = OP_MAX;
                2'b10:   op = '0;
                default: op = '1;
            endcase
        end else begin
            case (s)
                3'b000:  op = OP_MIN;
                3'b111:  op = OP_MAX;
                3'b001:  op = '0;
                default: op = data;
            endcase
        end
        return op;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Operand fields always come from the current (pre-step) LFSR value
    always_comb begin
        sel      = lfsr[2:0];
        errf     = lfsr[3 +: ERR_W];
        gen_data = lfsr[31 -: DATA_W];
        gen_op   = pick_operand(mode, sel, gen_data);
        gen_inj  = (mode != 2'd3) && (&errf);
        gen_par  = (^gen_op) ^ gen_inj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lfsr         <= SEED_EFF;
            count_lat    <= '0;
            wait_cnt     <= '0;
            arg_a        <= '0;
            arg_a_parity <= 1'b0;
            arg_b        <= '0;
            arg_b_parity <= 1'b0;
            req          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_cnt       <= '0;
            err_cnt      <= '0;
            tmo_cnt      <= '0;
        end else begin
            req  <= 1'b0;
            done <= 1'b0;
            if (state == S_GEN_A || state == S_GEN_B) begin
                lfsr <= lfsr_step(lfsr);
            end
            // abort wins over start and result_valid; counters and operands hold
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            count_lat <= count;
                            tx_cnt    <= '0;
                            err_cnt   <= '0;
                            tmo_cnt   <= '0;
                            busy      <= 1'b1;
                            if (count == 16'd0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_GEN_A;
                            end
                        end
                    end
                    S_GEN_A: begin
                        arg_a        <= gen_op;
                        arg_a_parity <= gen_par;
                        if (gen_inj) err_cnt <= sat_inc(err_cnt);
                        state <= S_GEN_B;
                    end
                    S_GEN_B: begin
                        arg_b        <= gen_op;
                        arg_b_parity <= gen_par;
                        if (gen_inj) err_cnt <= sat_inc(err_cnt);
                        req   <= 1'b1;
                        state <= S_SEND;
                    end
                    S_SEND: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (result_valid || wait_cnt == WAIT_LAST) begin
                            tx_cnt <= tx_cnt + 16'd1;
                            if (!result_valid) tmo_cnt <= sat_inc(tmo_cnt);
                            if (tx_cnt + 16'd1 == count_lat) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_GEN_A;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_stim_gen.sv
// Randomized bench for mult_stim_gen against a behavioural model of the operand
// stream, handshake timing and run counters.
module tb_mult_stim_gen;

    localparam int          DW     = 16;
    localparam int          EW     = 2;
    localparam int          TMO    = 64;
    localparam int unsigned SEED_V = 32'hACE1_1234;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] count;
    logic        result_valid;
    logic [DW-1:0] arg_a;
    logic        arg_a_parity;
    logic [DW-1:0] arg_b;
    logic        arg_b_parity;
    logic        req;
    logic        busy;
    logic        done;
    logic [15:0] tx_cnt;
    logic [15:0] err_cnt;
    logic [15:0] tmo_cnt;

    int          total;
    int          bad;
    int unsigned m_lfsr;
    int          exp_err;
    logic [3:0]  seen_mask;
    logic [16:0] got_a[$];
    logic [16:0] got_b[$];
    logic [16:0] ref_a[$];
    logic [16:0] ref_b[$];

    mult_stim_gen #(
        .DATA_W (DW),
        .ERR_W  (EW),
        .SEED   (SEED_V),
        .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .count       (count),
        .result_valid(result_valid),
        .arg_a       (arg_a),
        .arg_a_parity(arg_a_parity),
        .arg_b       (arg_b),
        .arg_b_parity(arg_b_parity),
        .req         (req),
        .busy        (busy),
        .done        (done),
        .tx_cnt      (tx_cnt),
        .err_cnt     (err_cnt),
        .tmo_cnt     (tmo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned m_step(input int unsigned l);
        if (l % 2 == 1) return (l / 2) ^ 32'h8020_0003;
        return l / 2;
    endfunction

    // Next operand from the model LFSR, following the mode/parity rules
    task automatic m_gen(input int md, output logic [15:0] v, output logic p);
        int unsigned sel;
        int unsigned errf;
        logic [15:0] data;
        bit          inj;
        sel  = m_lfsr % 8;
        errf = (m_lfsr / 8) % 4;
        data = 16'(m_lfsr / 65536);
        if (md == 1) begin
            v = data;
        end else if (md == 2) begin
            case (sel % 4)
                0:       v = 16'h8000;
                1:       v = 16'h7FFF;
                2:       v = 16'h0000;
                default: v = 16'hFFFF;
            endcase
        end else if (sel == 0) v = 16'h8000;
        else if (sel == 7)     v = 16'h7FFF;
        else if (sel == 1)     v = 16'h0000;
        else                   v = data;
        inj = (md != 3) && (errf == 3);
        p   = (($countones(v) % 2) == 1) ^ inj;
        if (inj) exp_err++;
        m_lfsr = m_step(m_lfsr);
    endtask

    task automatic note_corner(input logic [15:0] v);
        int idx;
        case (v)
            16'h8000: idx = 0;
            16'h7FFF: idx = 1;
            16'h0000: idx = 2;
            16'hFFFF: idx = 3;
            default:  idx = 4;
        endcase
        chk_val("corner_set", 64'(idx < 4), 64'd1);
        if (idx < 4) seen_mask[idx] = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk_val(tag, 64'({arg_a, arg_a_parity, arg_b, arg_b_parity, req, busy, done}), 64'd0);
        chk_val(tag, 64'({tx_cnt, err_cnt, tmo_cnt}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        m_lfsr = SEED_V;
        chk_reset("reset_state");
    endtask

    // intr: 0 none, 1 abort, 2 rst -- applied in the first WAIT cycle of transaction intr_tx
    task automatic run(input int md, input int cnt, input bit no_rv, input int intr, input int intr_tx);
        int c, nreq, rv_at, exp_req, exp_done, evt, last_req, d, tmo_n, budget;
        bit seen_done, stop, acc;
        logic [15:0] ea, eb;
        logic pa, pb;
        exp_err   = 0;
        seen_mask = '0;
        mode  = 2'(md);
        count = 16'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0; nreq = 0; rv_at = -1; exp_req = 2; exp_done = (cnt == 0) ? 0 : -1;
        evt = 0; last_req = -10; tmo_n = 0; seen_done = 1'b0; stop = 1'b0; d = 0;
        budget = cnt * 80 + 40;
        while (!seen_done && !stop && c < budget) begin
            if (req) begin
                chk_val("req_cycle", 64'(c), 64'(exp_req));
                m_gen(md, ea, pa);
                m_gen(md, eb, pb);
                chk_val("arg_a", 64'(arg_a), 64'(ea));
                chk_val("arg_a_parity", 64'(arg_a_parity), 64'(pa));
                chk_val("arg_b", 64'(arg_b), 64'(eb));
                chk_val("arg_b_parity", 64'(arg_b_parity), 64'(pb));
                if (md == 3) begin
                    chk_val("par_a_xor", 64'(arg_a_parity), 64'(^arg_a));
                    chk_val("par_b_xor", 64'(arg_b_parity), 64'(^arg_b));
                end
                if (md == 2) begin
                    note_corner(arg_a);
                    note_corner(arg_b);
                end
                got_a.push_back({arg_a_parity, arg_a});
                got_b.push_back({arg_b_parity, arg_b});
                nreq++;
                last_req = c;
                if (no_rv) begin
                    evt = c + TMO;
                    tmo_n++;
                end else begin
                    d   = int'($urandom_range(12, 1));
                    evt = c + d;
                end
                rv_at   = no_rv ? -1 : evt;
                exp_req = evt + 3;
                if (nreq == cnt) exp_done = evt + 1;
            end
            if (done) begin
                chk_val("done_cycle", 64'(c), 64'(exp_done));
                seen_done = 1'b1;
            end else begin
                result_valid = (c == rv_at) || (!no_rv && req && ($urandom_range(1, 0) == 1));
                start = ($urandom_range(7, 0) == 0);
                count = 16'($urandom);
                if (intr != 0 && nreq == intr_tx && c == last_req + 1) begin
                    if (intr == 1) abort = 1'b1;
                    else           rst   = 1'b1;
                    stop = 1'b1;
                end
                tick();
                c++;
            end
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; result_valid = 1'b0;
        chk_val("run_end", 64'(seen_done || stop), 64'd1);
        if (seen_done) begin
            chk_val("tx_cnt", 64'(tx_cnt), 64'(cnt));
            chk_val("tmo_cnt", 64'(tmo_cnt), 64'(tmo_n));
            chk_val("err_cnt", 64'(err_cnt), 64'(exp_err));
            tick();
            chk_val("done_pulse", 64'({done, busy}), 64'd0);
        end else if (stop && intr == 1) begin
            chk_val("abort_busy", 64'(busy), 64'd0);
            chk_val("abort_tx_cnt", 64'(tx_cnt), 64'(intr_tx - 1));
            chk_val("abort_err_cnt", 64'(err_cnt), 64'(exp_err));
            acc = 1'b0;
            for (int i = 0; i < 6; i++) begin
                acc = acc | req | done;
                tick();
            end
            chk_val("abort_quiet", 64'(acc), 64'd0);
        end else if (stop) begin
            chk_reset("rst_mid_run");
            m_lfsr = SEED_V;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_err = 0; m_lfsr = SEED_V; seen_mask = '0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; count = 16'd0; result_valid = 1'b0;
        do_reset();

        run(3, 100, 1'b0, 0, 0);
        run(0, 0, 1'b0, 0, 0);
        run(2, 200, 1'b0, 0, 0);
        chk_val("corners_seen", 64'(seen_mask), 64'hF);
        run(1, 3, 1'b1, 0, 0);
        run(0, 10, 1'b0, 1, 5);
        run(1, 4, 1'b0, 0, 0);

        do_reset();
        got_a.delete();
        got_b.delete();
        run(0, 20, 1'b0, 2, 7);
        ref_a = got_a;
        ref_b = got_b;
        got_a.delete();
        got_b.delete();
        run(0, 7, 1'b0, 0, 0);
        chk_val("rerun_len", 64'(got_a.size()), 64'(ref_a.size()));
        for (int i = 0; i < 7; i++) begin
            chk_val("rerun_a", 64'(got_a[i]), 64'(ref_a[i]));
            chk_val("rerun_b", 64'(got_b[i]), 64'(ref_b[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_stim_gen.md
Name: mult_stim_gen

Overview:
- Synthesizable, parametrised stimulus generator for the signed parity-checked multiplier.
- Produces operand pairs with parity bits from an internal LFSR and drives them to the DUT with a request pulse.
- Waits for the DUT result handshake, with timeout recovery, before issuing the next pair.
- Adds run-time mode selection, programmable transaction count, controllable parity-error injection and status counters, so long regressions and on-FPGA self-test need no testbench processes.

Parameters:
- DATA_W, 16: operand width. Legal range 4..(29-ERR_W).
- ERR_W, 2: parity error injected when LFSR error field is all ones, i.e. rate 2^-ERR_W. Legal range 1..4.
- SEED, 32'hACE1_1234: LFSR reset value. A value of 0 is replaced by 1.
- TIMEOUT, 64: maximum WAIT cycles before a transaction is abandoned. Must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run. Sampled only in IDLE.
- abort  in  1  synchronous stop of the current run.
- mode  in  2  0 mixed; 1 random only; 2 corners only; 3 mixed, no parity errors.
- count  in  16  transactions per run. Latched on start.
- result_valid  in  1  DUT result-ready strobe.
- arg_a  out  DATA_W  signed operand A.
- arg_a_parity  out  1  parity for A.
- arg_b  out  DATA_W  signed operand B.
- arg_b_parity  out  1  parity for B.
- req  out  1  one-cycle operand-valid pulse.
- busy  out  1  high in all states except IDLE.
- done  out  1  one-cycle end-of-run pulse.
- tx_cnt  out  16  transactions completed in this run.
- err_cnt  out  16  operands sent with wrong parity. Saturates at 16'hFFFF.
- tmo_cnt  out  16  transactions that timed out. Saturates at 16'hFFFF.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE.
  - LFSR is loaded with SEED.
  - The latched count and the wait counter are cleared.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
  - Steps exactly once in each GEN_A and GEN_B cycle, and at no other time.
  - Fields are taken from the pre-step value: sel=L[2:0], errf=L[3 +: ERR_W], data=L[31 -: DATA_W].
- Operand value by mode:
  - Modes 0 and 3: sel 000 gives the signed minimum (MSB=1, rest 0); 111 gives the signed maximum; 001 gives 0; any other value gives data.
  - Mode 1: data.
  - Mode 2: sel[1:0] 00 gives min, 01 max, 10 zero, 11 all ones (-1).
- Parity:
  - Correct parity is the XOR of all operand bits.
  - In modes 0, 1 and 2 the parity is inverted when errf is all ones, and err_cnt increments for that operand.
  - Mode 3 never inverts parity.
  - mode is sampled on each GEN cycle.
- FSM: IDLE → GEN_A → GEN_B → SEND → WAIT → (GEN_A | DONE) → IDLE.
  - IDLE: start=1 latches count and clears tx_cnt, err_cnt and tmo_cnt. Goes to DONE if count==0, otherwise to GEN_A.
  - GEN_A: loads arg_a and arg_a_parity. GEN_B: loads arg_b and arg_b_parity.
  - SEND: req=1 for exactly this cycle; clears the wait counter.
  - WAIT: result_valid=1 increments tx_cnt. Otherwise, after TIMEOUT WAIT cycles, tmo_cnt and tx_cnt increment. On either event the FSM goes to DONE if the new tx_cnt equals the latched count, otherwise to GEN_A.
  - DONE: done=1 for this cycle only, then IDLE.
- Latency:
  - start high at edge k gives GEN_A in cycle k+1 and req in cycle k+3.
  - result_valid in WAIT cycle j gives the next req in cycle j+3.
- Holding rules:
  - arg_* and parity hold their last values between GEN loads and after the run ends.
  - Counters hold after done until the next accepted start.
- Boundary cases:
  - result_valid outside WAIT (including the SEND cycle) is ignored.
  - start while busy is ignored.
  - A change to count during a run has no effect.
- abort:
  - Any state goes to IDLE next cycle; req stays 0 and done is not pulsed.
  - Counters and outputs hold.
  - abort takes priority over start and result_valid in the same cycle.
  - rst takes priority over abort.
- rst mid-run: all outputs and state return to reset values at the next edge. The LFSR is reseeded, so the next run repeats the same sequence.
- Mode 3 guarantees err_cnt=0.

Test Plan:
- count=0, start pulse → done=1 exactly one cycle later, req never asserted, all counters 0.
- mode=3, count=100, result_valid 2 cycles after each req → 100 req pulses; every parity equals the XOR of its operand; err_cnt=0, tmo_cnt=0, tx_cnt=100; operands match the LFSR model from SEED.
- mode=2, count=200 → every arg_a and arg_b is in {min, max, 0, -1} (16'h8000/7FFF/0000/FFFF); all four values seen; err_cnt matches the model (about 25% of 400 operands).
- result_valid tied 0, TIMEOUT=64, count=3 → req spacing 67 cycles; tmo_cnt=3, tx_cnt=3; done in cycle start+3+3*67-ish, exact value from the model.
- abort asserted in WAIT of transaction 5 with count=10 → busy=0 next cycle, no done, tx_cnt=4; a following start clears the counters and restarts from the current LFSR state.
- rst asserted at transaction 7, then rerun with count=7 → operand sequence is bit-identical to the first 7 transactions of the pre-reset run.
